// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - job sequencer that fills, feeds, drains and reads out an N x N systolic array
module systolic_array_ctrl #(
    parameter int N = 4,
    parameter int W = 32,
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [N*W-1:0]       src_x,
    input  logic [N*W-1:0]       src_w,
    output logic                 arr_start,
    output logic [N*W-1:0]       arr_x_in,
    output logic [N*W-1:0]       arr_w_in,
    input  logic                 arr_stall,
    input  logic [N*N*W-1:0]     arr_psum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N*W-1:0]       res_data,
    output logic [RW-1:0]        res_row,
    output logic [31:0]          perf_cycles
);

    // One counter is shared: fill slot f, run beat b and output row r are
    // never live at the same time. It must reach 3N-2 during RUN.
    localparam int CW = $clog2(3 * N);
    localparam int SW = $clog2(2 * N);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        OUT
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    idx, idx_n;
    logic [31:0]      perf_n;

    // Operand buffer: 2N beats of x and w, captured during FILL only.
    logic [N*W-1:0]   xbuf [0:2*N-1];
    logic [N*W-1:0]   wbuf [0:2*N-1];

    // Partial-sum matrix viewed as N rows, row 0 in the low bits.
    logic [N*W-1:0]   psum_row [0:N-1];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rows
            assign psum_row[gi] = arr_psum[gi*N*W +: N*W];
        end
    endgenerate

    // State, shared counter and performance counter; reset wins asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            perf_cycles <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            perf_cycles <= perf_n;
        end
    end

    // Buffer capture; contents are irrelevant until a full fill has completed.
    always_ff @(posedge clk) begin
        if (state == FILL && src_valid) begin
            xbuf[idx[SW-1:0]] <= src_x;
            wbuf[idx[SW-1:0]] <= src_w;
        end
    end

    assign busy = (state != IDLE);

    // Next-state and output decode; abort overrides every other transition.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        perf_n    = perf_cycles;
        src_ready = 1'b0;
        arr_start = 1'b0;
        arr_x_in  = '0;
        arr_w_in  = '0;
        res_valid = 1'b0;
        res_data  = '0;
        res_row   = '0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = FILL;
                    idx_n   = '0;
                    perf_n  = '0;
                end
            end

            FILL: begin
                src_ready = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (src_valid) begin
                    if (idx == CW'(2*N - 1)) begin
                        state_n = RUN;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end

            RUN: begin
                arr_start = 1'b1;
                if (perf_cycles != 32'hFFFF_FFFF) begin
                    perf_n = perf_cycles + 32'd1;
                end
                // Beats past the buffer are zero drain beats that push the
                // last operands through the array.
                if (idx < CW'(2*N)) begin
                    arr_x_in = xbuf[idx[SW-1:0]];
                    arr_w_in = wbuf[idx[SW-1:0]];
                end
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (!arr_stall) begin
                    if (idx == CW'(3*N - 2)) begin
                        state_n = FLUSH;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end

            FLUSH: begin
                arr_start = 1'b1;
                if (perf_cycles != 32'hFFFF_FFFF) begin
                    perf_n = perf_cycles + 32'd1;
                end
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (!arr_stall) begin
                    state_n = OUT;
                    idx_n   = '0;
                end
            end

            OUT: begin
                res_valid = 1'b1;
                res_row   = idx[RW-1:0];
                res_data  = psum_row[idx[RW-1:0]];
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (res_ready) begin
                    if (idx == CW'(N - 1)) begin
                        // Done fires inside OUT, so it can never coincide
                        // with a start being sampled in IDLE.
                        done    = 1'b1;
                        state_n = IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - randomized self-checking bench for systolic_array_ctrl
module tb_systolic_array_ctrl;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int RW = 2;
    localparam int VW = N * W;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               src_valid;
    logic               src_ready;
    logic [VW-1:0]      src_x;
    logic [VW-1:0]      src_w;
    logic               arr_start;
    logic [VW-1:0]      arr_x_in;
    logic [VW-1:0]      arr_w_in;
    logic               arr_stall;
    logic [N*VW-1:0]    arr_psum;
    logic               res_valid;
    logic               res_ready;
    logic [VW-1:0]      res_data;
    logic [RW-1:0]      res_row;
    logic [31:0]        perf_cycles;

    systolic_array_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_x       (src_x),
        .src_w       (src_w),
        .arr_start   (arr_start),
        .arr_x_in    (arr_x_in),
        .arr_w_in    (arr_w_in),
        .arr_stall   (arr_stall),
        .arr_psum    (arr_psum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_row     (res_row),
        .perf_cycles (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [VW-1:0] xs   [2*N];
    logic [VW-1:0] ws   [2*N];
    logic [VW-1:0] prow [N];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // IEEE-754 single encoding of a small non-negative integer.
    function automatic logic [31:0] f32(input int k);
        int e;
        logic [31:0] m;
        if (k == 0) return 32'h0;
        e = 0;
        while ((k >> (e + 1)) != 0) e++;
        m = 32'(k - (1 << e)) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic idle_inputs();
        start     = 1'b0;
        abort     = 1'b0;
        src_valid = 1'b0;
        arr_stall = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_arr_start"}, arr_start, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_arr_x"}, arr_x_in, 0);
        chk({tag, "_arr_w"}, arr_w_in, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_row"}, res_row, 0);
        chk({tag, "_perf"}, perf_cycles, 0);
    endtask

    // One job from start; the bench plays source, array and result sink.
    // stall_at/rr_at/abort_at/rst_row use -1 for "not used".
    task automatic run_job(input int stall_at, input int stall_len, input bit tog,
                           input int rr_at, input int rr_len, input int abort_at,
                           input int rst_row, input bit start_mid, input bit ident);
        logic [VW-1:0] cap_x [$];
        logic [VW-1:0] cap_w [$];
        logic [VW-1:0] hx, hw;
        int  sent = 0, cons = 0, rows = 0, cyc = 0;
        int  done_cyc = -1, acc_last = -1, first_arr = -1;
        int  stall_cnt = 0, rr_cnt = 0;
        bit  held = 0, fin = 0, aborted = 0, was_reset = 0, ab;

        for (int s = 0; s < 2*N; s++) begin
            for (int j = 0; j < N; j++) begin
                xs[s][j*W +: W] = ident ? f32((s*N + j) % 16 + 1) : $urandom;
                ws[s][j*W +: W] = ident ? ((j == s % N) ? f32(1) : 32'h0) : $urandom;
            end
        end
        // With identity weights the product equals X, i.e. 1.0 .. 16.0 row-major.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prow[i][j*W +: W] = ident ? f32(i*N + j + 1) : $urandom;
                arr_psum[(i*N + j)*W +: W] = prow[i][j*W +: W];
            end
        end

        while (!fin && cyc < 400) begin
            @(negedge clk);
            start     = (cyc == 0) || (start_mid && cons == 2);
            ab        = (abort_at >= 0) && !aborted && first_arr >= 0 && cons == abort_at;
            abort     = ab;
            src_valid = tog ? (cyc % 2 == 1) : 1'b1;
            src_x     = xs[(sent < 2*N) ? sent : 0];
            src_w     = ws[(sent < 2*N) ? sent : 0];
            arr_stall = (cons == stall_at) && (stall_cnt < stall_len);
            if (arr_stall) stall_cnt++;
            res_ready = !((rows == rr_at) && (rr_cnt < rr_len));
            if (!res_ready) rr_cnt++;
            if (rst_row >= 0 && rows == rst_row) rst = 1'b1;
            #1;
            if (rst) begin
                check_all_zero("async_rst");
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                #1;
                chk("post_rst_busy", busy, 0);
                was_reset = 1;
                fin = 1;
            end else begin
                if (src_valid && src_ready) begin
                    sent++;
                    if (sent == 2*N) acc_last = cyc;
                end
                if (arr_start && first_arr < 0) first_arr = cyc;
                if (held) begin
                    chk("stall_hold_x", arr_x_in, hx);
                    chk("stall_hold_w", arr_w_in, hw);
                end
                held = arr_start && arr_stall;
                hx   = arr_x_in;
                hw   = arr_w_in;
                if (arr_start && !arr_stall) begin
                    cap_x.push_back(arr_x_in);
                    cap_w.push_back(arr_w_in);
                    cons++;
                end
                if (res_valid && rows < N) begin
                    chk("res_row", res_row, rows);
                    chk("res_data", res_data, prow[rows]);
                    if (res_ready) rows++;
                end
                if (ab) begin
                    chk("abort_no_done", done, 0);
                    aborted = 1;
                end else if (aborted) begin
                    chk("abort_busy", busy, 0);
                    chk("abort_arr_start", arr_start, 0);
                    chk("abort_done", done, 0);
                    fin = 1;
                end
                if (done) begin
                    done_cyc = cyc;
                    chk("done_after_last_hs", rows, N);
                    fin = 1;
                end
            end
            cyc++;
        end
        if (!fin) chk("job_timeout", 0, 1);

        if (fin && !aborted && !was_reset) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("perf_cycles", perf_cycles, 3*N + stall_len);
            chk("run_after_last_beat", first_arr, acc_last + 1);
            chk("beat_count", cap_x.size(), 3*N);
            for (int k = 0; k < cap_x.size() && k < 3*N - 1; k++) begin
                chk("beat_x", cap_x[k], (k < 2*N) ? xs[k] : '0);
                chk("beat_w", cap_w[k], (k < 2*N) ? ws[k] : '0);
            end
            if (!tog && stall_len == 0 && rr_len == 0)
                chk("latency", done_cyc + 1, 6*N + 1);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst      = 1'b1;
        arr_psum = '0;
        src_x    = '0;
        src_w    = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        start = 1'b1;
        #1;
        check_all_zero("in_rst");
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("after_rst");

        // start and abort together in IDLE must not launch a job
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("start_abort_idle", busy, 0);

        run_job(-1, 0, 0, -1, 0, -1, -1, 0, 1);   // identity golden job
        run_job(-1, 0, 0, -1, 0, -1, -1, 0, 0);   // random data
        run_job(5, 3, 0, -1, 0, -1, -1, 0, 0);    // stall at b=5
        run_job(-1, 0, 1, -1, 0, -1, -1, 0, 0);   // toggling src_valid
        run_job(-1, 0, 0, 1, 2, -1, -1, 0, 0);    // res_ready low at r=1
        run_job(-1, 0, 0, -1, 0, 3, -1, 0, 0);    // abort at b=3
        run_job(-1, 0, 0, -1, 0, -1, -1, 0, 0);   // full job after abort
        run_job(-1, 0, 0, -1, 0, -1, -1, 1, 0);   // start while busy ignored
        run_job(-1, 0, 0, -1, 0, -1, 1, 0, 0);    // reset during OUT
        run_job(-1, 0, 0, -1, 0, -1, -1, 0, 1);   // full job after reset
        for (int t = 0; t < 4; t++) begin
            run_job($urandom_range(1, 3*N - 1), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                    $urandom_range(0, 2), -1, -1, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
